// File: rtl/regfile_pkg.sv
// Shared definitions for the general-purpose register file and the decode
// logic that drives it.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int NREGS_DEF  = 16;

   // Widest packed bus the slice helper accepts; callers zero-extend into it.
   localparam int SLICE_BUS_W = 1024;

   // Returns slice k (of width w) of a packed multi-port bus, right-aligned.
   function automatic logic [SLICE_BUS_W-1:0] busSlice(
      input logic [SLICE_BUS_W-1:0] bus,
      input int unsigned            k,
      input int unsigned            w
   );
      logic [SLICE_BUS_W-1:0] mask;
      if (w >= SLICE_BUS_W) begin
         mask = '1;
      end else begin
         mask = (SLICE_BUS_W'(1) << w) - SLICE_BUS_W'(1);
      end
      return (bus >> (k * w)) & mask;
   endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: zero-register override, write-through bypass
// and busy qualification against a same-cycle write.
module regfile_sb_rdport
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = $clog2(NREGS_DEF),
   parameter int ZERO_REG = 1
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] reg_data_i,
   input  logic              reg_busy_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_busy_o
);

   localparam logic ZeroEn = (ZERO_REG != 0);

   logic isZeroReg;
   logic writeHit;

   assign isZeroReg = ZeroEn && (addr_i == '0);
   assign writeHit  = wr_en_i && (wr_addr_i == addr_i);

   // A write landing this cycle both supplies the data and resolves the hazard.
   always_comb begin
      rd_data_o = reg_data_i;
      rd_busy_o = reg_busy_i;
      if (isZeroReg) begin
         rd_data_o = '0;
         rd_busy_o = 1'b0;
      end else if (writeHit) begin
         rd_data_o = wr_data_i;
         rd_busy_o = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with N bypassed read ports, optional hardwired
// zero register and a per-register busy scoreboard for RAW hazard tracking.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int ADDR_W   = $clog2(NREGS),
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int DBG_IDX  = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic                     wr_en_i,
   input  logic [ADDR_W-1:0]        wr_addr_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   input  logic                     claim_en_i,
   input  logic [ADDR_W-1:0]        claim_addr_i,
   output logic                     claim_stall_o,
   output logic                     err_unclaimed_o,
   output logic [DATA_W-1:0]        dbg_data_o
);

   localparam logic ZeroEn = (ZERO_REG != 0);

   if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : gNregsCheck
      $error("regfile_sb: NREGS must be a power of two and at least 2");
   end
   if (ADDR_W != $clog2(NREGS)) begin : gAddrCheck
      $error("regfile_sb: ADDR_W must equal clog2(NREGS)");
   end
   if ((DBG_IDX < 0) || (DBG_IDX >= NREGS)) begin : gDbgCheck
      $error("regfile_sb: DBG_IDX out of range");
   end

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [NREGS-1:0]  busy_q;
   logic [NREGS-1:0]  busy_d;
   logic              err_q;
   logic              err_d;

   logic wrWritable;
   logic claimWritable;
   logic claimTake;

   assign wrWritable    = wr_en_i && !(ZeroEn && (wr_addr_i == '0));
   assign claimWritable = claim_en_i && !(ZeroEn && (claim_addr_i == '0));

   // A claim only stalls on a live producer; a write this cycle retires it.
   assign claim_stall_o = claimWritable && busy_q[claim_addr_i]
                          && !(wr_en_i && (wr_addr_i == claim_addr_i));
   assign claimTake     = claimWritable && !claim_stall_o;

   // Claim is applied after the write so a new producer wins the busy bit.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      err_d  = err_q;
      if (wrWritable) begin
         regs_d[wr_addr_i] = wr_data_i;
         busy_d[wr_addr_i] = 1'b0;
         if (!busy_q[wr_addr_i]) begin
            err_d = 1'b1;
         end
      end
      if (claimTake) begin
         busy_d[claim_addr_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : gRdPort
      logic [ADDR_W-1:0] portAddr;
      assign portAddr = rd_addr_i[k*ADDR_W +: ADDR_W];

      regfile_sb_rdport #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) uRdPort (
         .addr_i     (portAddr),
         .reg_data_i (regs_q[portAddr]),
         .reg_busy_i (busy_q[portAddr]),
         .wr_en_i    (wr_en_i),
         .wr_addr_i  (wr_addr_i),
         .wr_data_i  (wr_data_i),
         .rd_data_o  (rd_data_o[k*DATA_W +: DATA_W]),
         .rd_busy_o  (rd_busy_o[k])
      );
   end

   assign err_unclaimed_o = err_q;
   assign dbg_data_o      = regs_q[DBG_IDX];

endmodule
